// File: rtl/rope_pkg.sv
// rope_pkg: shared definitions for the rope sequencer.
//   - phase encoding (SWING/EXTEND/RETRACT/SCORE)
//   - retract step table indexed by object weight
//   - not-grabbed retract step
//   - geometry widths (10-bit outputs, 11-bit intermediate for overflow-free math)
package rope_pkg;

   localparam int GEO_W = 10;
   localparam int INT_W = 11;

   typedef enum logic [1:0] {
      ST_SWING   = 2'd0,
      ST_EXTEND  = 2'd1,
      ST_RETRACT = 2'd2,
      ST_SCORE   = 2'd3
   } rope_state_t;

   localparam logic [GEO_W-1:0] STEP_FREE = GEO_W'(4);

   // Weight 3 returns 1 here; the every-other-tick gating is applied by the caller.
   function automatic logic [GEO_W-1:0] retract_step(input logic [1:0] weight);
      logic [GEO_W-1:0] step;
      case (weight)
         2'd0:    step = GEO_W'(4);
         2'd1:    step = GEO_W'(2);
         default: step = GEO_W'(1);
      endcase
      return step;
   endfunction

endpackage

// File: rtl/rope_sequencer_key_rise.sv
// key_rise: registered rising-edge detector for a key level.
//   clock  in  system clock
//   resetn in  async active-low reset
//   din    in  key level
//   rise   out one-cycle pulse, the cycle after din is first seen high
// The history register runs regardless of any enable so that a key held
// through a pause is not seen as a new press afterwards.
module key_rise (
   input  logic clock,
   input  logic resetn,
   input  logic din,
   output logic rise
);

   logic prev_q;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         prev_q <= 1'b0;
         rise   <= 1'b0;
      end else begin
         prev_q <= din;
         rise   <= din & ~prev_q;
      end
   end

endmodule

// File: rtl/rope_sequencer.sv
// rope_sequencer: swing / extend / retract / score sequencing of the miner's rope.
// Motion advances only on a qualified tick (tick & enable & ~draw_busy).
//   clock, resetn          clock and async active-low reset
//   enable                 low freezes every register except the key edge history
//   tick, draw_busy        motion strobe and renderer-busy qualifier
//   go                     launch key level (rising edge used)
//   hit, hit_weight,       collision and the hit object's weight/value,
//   hit_value              sampled in EXTEND only
//   degree, rope_len       rope geometry for renderer and collision checker
//   state                  current phase (see table)
//   grabbed                object attached
//   score_valid, score_add one-cycle delivery pulse and value
// Optional feature macro ROPE_BOMB_EN adds BOMB_INIT, bomb_key, bomb_count and
// bomb_use: a bomb press during a loaded retract drops the object.
//
// state   | meaning
// SWING   | rope sweeps between DEG_MIN and DEG_MAX, waiting for go
// EXTEND  | rope grows by EXT_STEP per tick until hit or LEN_MAX
// RETRACT | rope shrinks at a weight-dependent rate down to LEN_MIN
// SCORE   | single cycle: deliver score if grabbed, then back to SWING
module rope_sequencer
   import rope_pkg::*;
#(
   parameter int DEG_MIN  = 10,
   parameter int DEG_MAX  = 170,
   parameter int LEN_MIN  = 20,
   parameter int LEN_MAX  = 400,
   parameter int EXT_STEP = 4
`ifdef ROPE_BOMB_EN
   ,
   parameter int BOMB_INIT = 3
`endif
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             enable,
   input  logic             tick,
   input  logic             draw_busy,
   input  logic             go,
   input  logic             hit,
   input  logic [1:0]       hit_weight,
   input  logic [9:0]       hit_value,
`ifdef ROPE_BOMB_EN
   input  logic             bomb_key,
   output logic [3:0]       bomb_count,
   output logic             bomb_use,
`endif
   output logic [9:0]       degree,
   output logic [9:0]       rope_len,
   output logic [1:0]       state,
   output logic             grabbed,
   output logic             score_valid,
   output logic [9:0]       score_add
);

   localparam logic [GEO_W-1:0] DEG_MIN_V = GEO_W'(DEG_MIN);
   localparam logic [GEO_W-1:0] DEG_MAX_V = GEO_W'(DEG_MAX);
   localparam logic [GEO_W-1:0] LEN_MIN_V = GEO_W'(LEN_MIN);
   localparam logic [GEO_W-1:0] LEN_MAX_V = GEO_W'(LEN_MAX);

   rope_state_t       state_q;
   logic [GEO_W-1:0]  degree_q;
   logic              dir_up_q;
   logic [GEO_W-1:0]  rope_len_q;
   logic              grabbed_q;
   logic              score_valid_q;
   logic [GEO_W-1:0]  score_add_q;
   logic [1:0]        wt_q;
   logic [GEO_W-1:0]  val_q;
   logic              parity_q;

   logic              go_rise;
   logic              qtick;
   logic [INT_W-1:0]  ext_sum;
   logic              ext_sat;
   logic [GEO_W-1:0]  ret_step;
   logic [INT_W-1:0]  ret_floor;
   logic              ret_done;
   logic [GEO_W-1:0]  ret_diff;
   logic              bomb_fire;

   key_rise u_go_rise (
      .clock  (clock),
      .resetn (resetn),
      .din    (go),
      .rise   (go_rise)
   );

`ifdef ROPE_BOMB_EN
   logic              bomb_rise;
   logic [3:0]        bomb_count_q;
   logic              bomb_use_q;

   key_rise u_bomb_rise (
      .clock  (clock),
      .resetn (resetn),
      .din    (bomb_key),
      .rise   (bomb_rise)
   );

   assign bomb_fire  = bomb_rise & grabbed_q & (bomb_count_q != 4'd0) &
                       (state_q == ST_RETRACT);
   assign bomb_count = bomb_count_q;
   assign bomb_use   = bomb_use_q;
`else
   assign bomb_fire  = 1'b0;
`endif

   assign qtick = tick & enable & ~draw_busy;

   always_comb begin
      ext_sum   = {1'b0, rope_len_q} + INT_W'(EXT_STEP);
      ext_sat   = (ext_sum >= INT_W'(LEN_MAX));
      ret_step  = STEP_FREE;
      if (grabbed_q) begin
         if (wt_q == 2'd3) begin
            // heavy objects move one pixel on every second qualified tick
            ret_step = parity_q ? GEO_W'(1) : GEO_W'(0);
         end else begin
            ret_step = retract_step(wt_q);
         end
      end
      ret_floor = INT_W'(LEN_MIN) + {1'b0, ret_step};
      ret_done  = ({1'b0, rope_len_q} <= ret_floor);
      ret_diff  = rope_len_q - ret_step;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_SWING;
         degree_q      <= DEG_MIN_V;
         dir_up_q      <= 1'b1;
         rope_len_q    <= LEN_MIN_V;
         grabbed_q     <= 1'b0;
         score_valid_q <= 1'b0;
         score_add_q   <= '0;
         wt_q          <= '0;
         val_q         <= '0;
         parity_q      <= 1'b0;
`ifdef ROPE_BOMB_EN
         bomb_count_q  <= 4'(BOMB_INIT);
         bomb_use_q    <= 1'b0;
`endif
      end else if (enable) begin
`ifdef ROPE_BOMB_EN
         bomb_use_q <= 1'b0;
`endif
         case (state_q)
            ST_SWING: begin
               if (go_rise) begin
                  state_q <= ST_EXTEND;
               end else if (qtick) begin
                  // at an endpoint the tick only turns the rope around
                  if (dir_up_q) begin
                     if (degree_q == DEG_MAX_V) dir_up_q <= 1'b0;
                     else                       degree_q <= degree_q + GEO_W'(1);
                  end else begin
                     if (degree_q == DEG_MIN_V) dir_up_q <= 1'b1;
                     else                       degree_q <= degree_q - GEO_W'(1);
                  end
               end
            end

            ST_EXTEND: begin
               if (qtick) begin
                  rope_len_q <= ext_sat ? LEN_MAX_V : ext_sum[GEO_W-1:0];
               end
               if (hit) begin
                  wt_q      <= hit_weight;
                  val_q     <= hit_value;
                  grabbed_q <= 1'b1;
                  parity_q  <= 1'b0;
                  state_q   <= ST_RETRACT;
               end else if (qtick && ext_sat) begin
                  grabbed_q <= 1'b0;
                  parity_q  <= 1'b0;
                  state_q   <= ST_RETRACT;
               end
            end

            ST_RETRACT: begin
               if (qtick) begin
                  parity_q <= ~parity_q;
                  if (ret_done) begin
                     rope_len_q    <= LEN_MIN_V;
                     state_q       <= ST_SCORE;
                     score_valid_q <= grabbed_q & ~bomb_fire;
                     score_add_q   <= (grabbed_q & ~bomb_fire) ? val_q : '0;
                  end else begin
                     rope_len_q <= ret_diff;
                  end
               end
`ifdef ROPE_BOMB_EN
               if (bomb_fire) begin
                  grabbed_q    <= 1'b0;
                  val_q        <= '0;
                  bomb_count_q <= bomb_count_q - 4'd1;
                  bomb_use_q   <= 1'b1;
               end
`endif
            end

            ST_SCORE: begin
               score_valid_q <= 1'b0;
               score_add_q   <= '0;
               grabbed_q     <= 1'b0;
               state_q       <= ST_SWING;
            end
         endcase
      end
   end

   assign degree      = degree_q;
   assign rope_len    = rope_len_q;
   assign state       = state_q;
   assign grabbed     = grabbed_q;
   assign score_valid = score_valid_q;
   assign score_add   = score_add_q;

endmodule
